// File: rtl/regfile_write_arb.sv
// rtl/regfile_write_arb.sv - round-robin write-port arbiter with post-reset zeroing of X0..X30
module regfile_write_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    reqAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    reqData,
  output logic [NUM_REQ-1:0]               ack,
  output logic [ADDR_WIDTH-1:0]            writeReg,
  output logic [DATA_WIDTH-1:0]            writeData,
  output logic                             regWrite,
  output logic                             initDone
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_INIT = ADDR_WIDTH'(NUM_REGS - 2);
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG  = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1
  } state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [PW-1:0]           ptr;
  logic                    grant_valid;
  logic [PW-1:0]           grant;
  logic [ADDR_WIDTH-1:0]   grant_addr;
  logic [DATA_WIDTH-1:0]   grant_data;

  // Scan from farthest to nearest so the requester closest to ptr overwrites the rest.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant       = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    grant_addr = reqAddr[int'(grant) * ADDR_WIDTH +: ADDR_WIDTH];
    grant_data = reqData[int'(grant) * DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = INIT;
    ack        = '0;
    case (state)
      INIT: next_state = (cnt == LAST_INIT) ? RUN : INIT;
      RUN: begin
        next_state = RUN;
        if (grant_valid && !reset) begin
          ack[grant] = 1'b1;
        end
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      ptr       <= '0;
      writeReg  <= '0;
      writeData <= '0;
      regWrite  <= 1'b0;
      initDone  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          writeReg  <= cnt;
          writeData <= '0;
          regWrite  <= 1'b1;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_INIT) begin
            initDone <= 1'b1;
          end
        end
        RUN: begin
          if (grant_valid) begin
            writeReg  <= grant_addr;
            writeData <= grant_data;
            // X31 is hardwired zero: the grant is consumed but nothing is written.
            regWrite  <= (grant_addr != ZERO_REG);
            ptr       <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
          end else begin
            regWrite <= 1'b0;
          end
        end
        default: begin
          cnt      <= '0;
          regWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arb.sv
// tb/tb_regfile_write_arb.sv - vector table, corner sequences and random run against a reference model
module tb_regfile_write_arb;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] reqAddr = '0;
  logic [N*DW-1:0] reqData = '0;
  logic [N-1:0]    ack;
  logic [AW-1:0]   writeReg;
  logic [DW-1:0]   writeData;
  logic            regWrite;
  logic            initDone;

  regfile_write_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .req(req), .reqAddr(reqAddr), .reqData(reqData),
    .ack(ack), .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .initDone(initDone)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: winner is the requester at the smallest rotational distance from ptr.
  function automatic int winner(input logic [N-1:0] r, input int p);
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++) begin
      if (r[i] && ((i - p + N) % N) < bd) begin
        bd = (i - p + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [AW-1:0] get_addr(input int g);
    return reqAddr[g*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] get_data(input int g);
    return reqData[g*DW +: DW];
  endfunction

  logic          m_run, m_we, m_done;
  int            m_cnt, m_ptr, m_g;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_wd;
  logic [N-1:0]  e_ack;

  always_comb m_g = winner(req, m_ptr);
  always_comb e_ack = (m_run && !reset && m_g >= 0) ? N'(1 << m_g) : '0;

  always @(posedge clk) begin
    if (reset) begin
      m_run <= 1'b0; m_cnt <= 0; m_ptr <= 0; m_we <= 1'b0;
      m_wr <= '0; m_wd <= '0; m_done <= 1'b0;
    end else if (!m_run) begin
      m_wr <= AW'(m_cnt); m_wd <= '0; m_we <= 1'b1; m_cnt <= m_cnt + 1;
      if (m_cnt == 30) begin
        m_run <= 1'b1; m_done <= 1'b1;
      end
    end else if (m_g >= 0) begin
      m_wr <= get_addr(m_g); m_wd <= get_data(m_g);
      m_we <= (get_addr(m_g) != 5'd31);
      m_ptr <= (m_g + 1) % N;
    end else begin
      m_we <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_ack", 64'(ack), 64'(e_ack));
      chk("model_regWrite", 64'(regWrite), 64'(m_we));
      chk("model_writeReg", 64'(writeReg), 64'(m_wr));
      chk("model_writeData", writeData, m_wd);
      chk("model_initDone", 64'(initDone), 64'(m_done));
    end
  end

  typedef struct {
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [DW-1:0]   d;
    logic [N-1:0]    ack;
    logic            we;
    logic [AW-1:0]   wr;
    logic [DW-1:0]   wd;
  } vec_t;

  vec_t tbl[15];

  task automatic drive(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic [DW-1:0] d);
    req = r;
    reqAddr = a;
    for (int i = 0; i < N; i++) reqData[i*DW +: DW] = d;
  endtask

  task automatic run_init_idle();
    for (int k = 0; k < 31; k++) begin
      @(posedge clk); #1;
      chk("init_regWrite", 64'(regWrite), 64'd1);
      chk("init_writeReg", 64'(writeReg), 64'(k));
      chk("init_writeData", writeData, 64'd0);
      chk("init_initDone", 64'(initDone), (k == 30) ? 64'd1 : 64'd0);
    end
  endtask

  logic [N-1:0]  rr;
  logic [AW-1:0] ra[N];
  logic [DW-1:0] rd[N];
  int            g;

  initial begin
    tbl[0]  = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd5},     64'hDEAD_BEEF, 4'b0001, 1'b1, 5'd5,  64'hDEAD_BEEF};
    tbl[1]  = '{4'b0000, {5'd0, 5'd0, 5'd0, 5'd5},     64'h1,         4'b0000, 1'b0, 5'd5,  64'hDEAD_BEEF};
    tbl[2]  = '{4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 64'h1111,      4'b0010, 1'b1, 5'd11, 64'h1111};
    tbl[3]  = '{4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 64'h2222,      4'b0100, 1'b1, 5'd12, 64'h2222};
    tbl[4]  = '{4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 64'h3333,      4'b1000, 1'b1, 5'd13, 64'h3333};
    tbl[5]  = '{4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 64'h4444,      4'b0001, 1'b1, 5'd10, 64'h4444};
    tbl[6]  = '{4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 64'h5555,      4'b0010, 1'b1, 5'd11, 64'h5555};
    tbl[7]  = '{4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 64'h6666,      4'b0100, 1'b1, 5'd12, 64'h6666};
    tbl[8]  = '{4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 64'h7777,      4'b1000, 1'b1, 5'd13, 64'h7777};
    tbl[9]  = '{4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 64'h8888,      4'b0001, 1'b1, 5'd10, 64'h8888};
    tbl[10] = '{4'b0100, {5'd0, 5'd31, 5'd0, 5'd0},    64'hFFFF,      4'b0100, 1'b0, 5'd31, 64'hFFFF};
    tbl[11] = '{4'b0011, {5'd0, 5'd0, 5'd7, 5'd6},     64'hA,         4'b0001, 1'b1, 5'd6,  64'hA};
    tbl[12] = '{4'b0011, {5'd0, 5'd0, 5'd7, 5'd6},     64'hB,         4'b0010, 1'b1, 5'd7,  64'hB};
    tbl[13] = '{4'b1001, {5'd9, 5'd0, 5'd0, 5'd8},     64'hC,         4'b1000, 1'b1, 5'd9,  64'hC};
    tbl[14] = '{4'b1001, {5'd9, 5'd0, 5'd0, 5'd8},     64'hD,         4'b0001, 1'b1, 5'd8,  64'hD};

    // Reset state
    drive(4'b1111, '0, '0);
    @(posedge clk); #1;
    chk_on = 1'b1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_regWrite", 64'(regWrite), 64'd0);
    chk("rst_initDone", 64'(initDone), 64'd0);
    chk("rst_writeReg", 64'(writeReg), 64'd0);

    // INIT sequence with idle requesters
    drive('0, '0, '0);
    reset = 1'b0;
    run_init_idle();
    @(posedge clk); #1;
    chk("post_init_regWrite", 64'(regWrite), 64'd0);

    // Table-driven RUN vectors, starting from ptr=0
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].req, tbl[i].addr, tbl[i].d);
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", i), 64'(ack), 64'(tbl[i].ack));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_regWrite", i), 64'(regWrite), 64'(tbl[i].we));
      chk($sformatf("tbl%0d_writeReg", i), 64'(writeReg), 64'(tbl[i].wr));
      chk($sformatf("tbl%0d_writeData", i), writeData, tbl[i].wd);
    end
    drive('0, '0, '0);

    // Requests held through INIT are ignored; first RUN cycle grants requester 0
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 64'h55);
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      chk("init_req_ack", 64'(ack), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("first_run_ack", 64'(ack), 64'b0001);
    @(posedge clk); #1;
    drive('0, '0, '0);

    // Reset at INIT cnt=12
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("cnt12_writeReg", 64'(writeReg), 64'd11);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midinit_rst_regWrite", 64'(regWrite), 64'd0);
    chk("midinit_rst_initDone", 64'(initDone), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reinit_writeReg", 64'(writeReg), 64'd0);
    chk("reinit_regWrite", 64'(regWrite), 64'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("reinit_done", 64'(initDone), 64'd1);

    // Reset mid-RUN with a write in flight and pending requests
    drive(4'b0010, {5'd0, 5'd0, 5'd20, 5'd0}, 64'h77);
    @(posedge clk); #1;
    chk("inflight_regWrite", 64'(regWrite), 64'd1);
    reset = 1'b1;
    drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 64'h99);
    @(negedge clk);
    chk("midrun_rst_ack", 64'(ack), 64'd0);
    @(posedge clk); #1;
    chk("midrun_rst_regWrite", 64'(regWrite), 64'd0);
    chk("midrun_rst_initDone", 64'(initDone), 64'd0);
    reset = 1'b0;
    drive('0, '0, '0);
    repeat (31) @(posedge clk);
    #1;
    drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 64'h99);
    @(negedge clk);
    chk("ptr_reset_ack", 64'(ack), 64'b0001);
    @(posedge clk); #1;
    drive('0, '0, '0);

    // Random traffic; each requester holds its request until granted
    rr = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rr[i] && $urandom_range(0, 2) == 0) begin
          rr[i] = 1'b1;
          ra[i] = ($urandom_range(0, 5) == 0) ? 5'd31 : AW'($urandom_range(0, 6));
          rd[i] = {$urandom, $urandom};
        end
      end
      req = rr;
      for (int i = 0; i < N; i++) begin
        reqAddr[i*AW +: AW] = ra[i];
        reqData[i*DW +: DW] = rd[i];
      end
      @(negedge clk);
      g = m_g;
      @(posedge clk); #1;
      if (g >= 0) rr[g] = 1'b0;
    end
    drive('0, '0, '0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
